prefetch_unit: RTL and testbench
================================

# prefetch_unit

Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue between instruction memory and decode. Keeps a fetch PC, issues one word request at a time over the proc_req/mem_ready/valid handshake, and buffers returned words with their PC. Presents the oldest {PC, NPC, IR} to decode under a valid/stall handshake. A jump redirect (j/jPC) flushes the queue and discards any in-flight response.

## Interface
- bits, 32: address and instruction width.
- DEPTH, 4: queue entries; a power of two, at least 2.
- RESET_PC, 0: fetch PC loaded on reset; 4-byte aligned.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: asynchronous, active-low.
- j  in  1  redirect request from execute.
- jPC  in  bits  redirect target; sampled when j=1.
- stall  in  1  decode cannot accept this cycle.
- mem_ready  in  1  memory accepts a request this cycle.
- valid  in  1  Rdata holds the response this cycle.
- Rdata  in  bits  instruction word from memory.
- proc_req  out  1  request strobe to memory.
- Add  out  bits  request address; always equals the fetch PC.
- out_valid  out  1  the PC/NPC/IR outputs hold a queued instruction.
- PC  out  bits  address of the head instruction.
- NPC  out  bits  PC+4, modulo 2^bits.
- IR  out  bits  head instruction word.

## Operation
- **Fetch PC**
  - Loaded with jPC on j.
  - Otherwise incremented by 4 on request acceptance (proc_req & mem_ready).
  - Wraps modulo 2^bits.
- **Request FSM**
  - IDLE: nothing outstanding. proc_req = !j & (count + 0 < DEPTH). Acceptance -> WAIT.
  - WAIT: one request outstanding; proc_req = 0.
    - valid & !j: push {fetch-PC-at-issue, Rdata}, -> IDLE.
    - j & !valid: -> DROP.
    - j & valid: response discarded, -> IDLE.
  - DROP: outstanding response is stale; proc_req = 0. valid -> discard, -> IDLE.
  - The issue address is held in an internal register for the push.
- **Credit rule**
  - No request is issued unless count plus outstanding is less than DEPTH.
  - A push therefore never overflows the queue.
- **Queue**
  - Circular buffer with read and write pointers wrapping at DEPTH.
  - Pop when out_valid & !stall & !j.
  - Push and pop in the same cycle leave count unchanged. This is legal when full or empty.
- **Redirect (j=1)**
  - Clears count and pointers, suppresses pop and push for that cycle, and forces proc_req = 0.
  - The first request from jPC is driven the next cycle when the FSM is IDLE. In DROP it waits for the stale valid.
- **Empty head**
  - When out_valid = 0, PC, NPC and IR drive 0.
- **Unexpected response**
  - valid while IDLE is ignored.

## Timing
- **Reset values**
  - proc_req=0, out_valid=0, PC=0, NPC=0, IR=0.
  - Add=RESET_PC; FSM=IDLE; queue empty.
- **Release**
  - The first cycle after rst deasserts drives proc_req=1 with Add=RESET_PC.
- **Reset mid-operation**
  - Abandons any outstanding request and returns to the reset values.
  - A later valid is ignored because the FSM is IDLE.
- **Latency**
  - A response with valid at cycle N gives out_valid=1 at cycle N+1.
- **Throughput**
  - Memory with valid one cycle after acceptance gives one instruction every 2 cycles.
- **Output timing**
  - proc_req depends combinationally on j and the registered state.
  - out_valid, PC, NPC and IR depend only on registers.

## Configuration
- **PREFETCH_BYPASS_EN**
  - When defined: in WAIT with valid & !j and the queue empty, Rdata and the issue PC drive IR/PC/NPC in the same cycle, and out_valid=1 combinationally.
    - If stall=0, the word is consumed and not pushed.
    - If stall=1, it is pushed as normal.
  - When undefined: outputs come only from the queue, with the 1-cycle latency above.

## Test plan
- **Reset and first fetch:** RESET_PC=0x100; release rst, mem_ready=1, valid one cycle after acceptance with Rdata=0xA, 0xB, 0xC.
  - Add sequence 0x100, 0x104, 0x108.
  - Head shows PC=0x100, NPC=0x104, IR=0xA.
- **Fill to full:** DEPTH=4, stall=1, memory always ready.
  - Exactly 4 requests issued, then proc_req stays 0.
  - Deassert stall for 1 cycle: one pop and one new request.
- **Redirect in WAIT:** j=1 with jPC=0x200 while a request to 0x10C is outstanding.
  - The 0x10C response is dropped and the queue is empty.
  - The next request is 0x200 only after the stale valid.
- **Simultaneous j and valid:** response discarded, FSM to IDLE, request to jPC on the next cycle, out_valid=0.
- **Wrap-around:** RESET_PC=0xFFFFFFFC.
  - Head NPC=0x00000000; the second request address is 0x00000000.
- **Reset mid-WAIT:** assert rst, release, then pulse valid.
  - The pulse is ignored; the first request is to RESET_PC.

Source files
------------

// File: rtl/prefetch_unit.sv
// prefetch_unit: instruction-fetch front end with a DEPTH-entry prefetch queue.
// Keeps a fetch PC, issues one memory request at a time, buffers returned words
// with their PC, and presents the oldest {PC, NPC, IR} to decode.
// A redirect (j/jPC) flushes the queue and discards any in-flight response.
// Optional feature: define PREFETCH_BYPASS_EN to forward a response straight to
// decode in the same cycle when the queue is empty.
module prefetch_unit #(
  parameter int unsigned     bits     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [bits-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            j,
  input  logic [bits-1:0] jPC,
  input  logic            stall,
  input  logic            mem_ready,
  input  logic            valid,
  input  logic [bits-1:0] Rdata,
  output logic            proc_req,
  output logic [bits-1:0] Add,
  output logic            out_valid,
  output logic [bits-1:0] PC,
  output logic [bits-1:0] NPC,
  output logic [bits-1:0] IR
);

  localparam int unsigned     PtrW = $clog2(DEPTH);
  localparam logic [bits-1:0] Step = bits'(4);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [bits-1:0] fetch_pc_q, fetch_pc_d;
  logic [bits-1:0] issue_pc_q;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [bits-1:0] pc_mem [DEPTH];
  logic [bits-1:0] ir_mem [DEPTH];

  logic accept;
  logic resp_ok;
  logic push;
  logic pop;
  logic head_valid;
  logic bypass;

  assign Add        = fetch_pc_q;
  assign head_valid = (count_q != '0);
  assign accept     = proc_req & mem_ready;
  // A response that belongs to the current fetch stream.
  assign resp_ok    = (state_q == StWait) & valid & !j;
  assign pop        = head_valid & !stall & !j;

`ifdef PREFETCH_BYPASS_EN
  // Empty queue: forward the response directly; it is only queued if decode stalls.
  assign bypass = resp_ok & !head_valid;
  assign push   = resp_ok & !(bypass & !stall);
`else
  assign bypass = 1'b0;
  assign push   = resp_ok;
`endif

  // Request FSM next state and request strobe.
  always_comb begin
    state_d  = state_q;
    proc_req = 1'b0;
    case (state_q)
      StIdle: begin
        // Nothing outstanding, so the credit check reduces to "queue not full";
        // count never exceeds DEPTH, so its MSB flags full.
        proc_req = rst & !j & !count_q[PtrW];
        if (proc_req && mem_ready) state_d = StWait;
      end
      StWait: begin
        if (valid)  state_d = StIdle;
        else if (j) state_d = StDrop;
      end
      StDrop: begin
        if (valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Fetch PC: redirect wins over sequential advance; wraps naturally.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (j)           fetch_pc_d = jPC;
    else if (accept) fetch_pc_d = fetch_pc_q + Step;
  end

  // Queue occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Head presentation; outputs are zero when nothing is queued.
  always_comb begin
    out_valid = head_valid | bypass;
    PC        = '0;
    NPC       = '0;
    IR        = '0;
    if (head_valid) begin
      PC  = pc_mem[rd_ptr_q];
      NPC = pc_mem[rd_ptr_q] + Step;
      IR  = ir_mem[rd_ptr_q];
    end else if (bypass) begin
      PC  = issue_pc_q;
      NPC = issue_pc_q + Step;
      IR  = Rdata;
    end
  end

  // Control state: FSM, fetch PC, issue PC and queue pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (accept) issue_pc_q <= fetch_pc_q;
      if (j) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
      end
    end
  end

  // Queue storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q] <= issue_pc_q;
      ir_mem[wr_ptr_q] <= Rdata;
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed stimulus with a scoreboard. Stimulus pushes
// expected request addresses and expected decode heads into queues; a monitor
// on the falling edge pops and compares whenever the DUT issues or delivers.
module tb_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst, j, stall, mem_ready, valid;
  logic [31:0] jPC, Rdata;
  logic        proc_req, out_valid;
  logic [31:0] Add, PC, NPC, IR;

  prefetch_unit #(
    .bits    (32),
    .DEPTH   (4),
    .RESET_PC(32'h0000_0100)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .j        (j),
    .jPC      (jPC),
    .stall    (stall),
    .mem_ready(mem_ready),
    .valid    (valid),
    .Rdata    (Rdata),
    .proc_req (proc_req),
    .Add      (Add),
    .out_valid(out_valid),
    .PC       (PC),
    .NPC      (NPC),
    .IR       (IR)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_req[$];
  logic [95:0] exp_ins[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle state check requested by stimulus, evaluated by the monitor.
  bit          sc_on = 1'b0;
  string       sc_name = "";
  int          sc_preq = -1;
  int          sc_ov = -1;
  bit          sc_add_on = 1'b0;
  logic [31:0] sc_add = '0;
  bit          sc_head_on = 1'b0;
  logic [95:0] sc_head = '0;
  bit          done = 1'b0;
  bit          done_seen = 1'b0;

  bit          auto_mem = 1'b1;
  bit          acc;
  logic [31:0] last_add;

  // Memory image: 0x100 -> 0xA, 0x104 -> 0xB, ... (linear in the word index).
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ((a - 32'h100) >> 2) + 32'hA;
  endfunction

  task automatic cmp(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: scoreboard pops plus stimulus-requested state checks.
  always @(negedge clk) begin
    if (proc_req && mem_ready) begin
      if (exp_req.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: Add=%h with no request expected", Add);
      end else begin
        cmp("req_addr", {64'd0, Add}, {64'd0, exp_req.pop_front()});
      end
    end
    if (out_valid && !stall && !j) begin
      if (exp_ins.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ins: PC=%h IR=%h with no instruction expected", PC, IR);
      end else begin
        cmp("head_pc_npc_ir", {PC, NPC, IR}, exp_ins.pop_front());
      end
    end
    if (sc_on) begin
      if (sc_preq >= 0) cmp({sc_name, "/proc_req"}, {95'd0, proc_req}, 96'(sc_preq));
      if (sc_ov >= 0)   cmp({sc_name, "/out_valid"}, {95'd0, out_valid}, 96'(sc_ov));
      if (sc_add_on)    cmp({sc_name, "/Add"}, {64'd0, Add}, {64'd0, sc_add});
      if (sc_head_on)   cmp({sc_name, "/head"}, {PC, NPC, IR}, sc_head);
    end
    if (done && !done_seen) begin
      done_seen <= 1'b1;
      cmp("req_left", 96'(exp_req.size()), 96'd0);
      cmp("ins_left", 96'(exp_ins.size()), 96'd0);
    end
  end

  task automatic step();
    @(negedge clk);
    acc      = proc_req && mem_ready;
    last_add = Add;
    @(posedge clk);
    #1;
    sc_on = 1'b0;
    if (auto_mem) begin
      valid = acc;
      Rdata = acc ? word_of(last_add) : 32'h0;
    end
  endtask

  task automatic expect_st(input string name, input int preq, input int ov,
                           input bit add_on, input logic [31:0] add);
    sc_on      = 1'b1;
    sc_name    = name;
    sc_preq    = preq;
    sc_ov      = ov;
    sc_add_on  = add_on;
    sc_add     = add;
    sc_head_on = 1'b0;
  endtask

  task automatic expect_head(input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] ir);
    sc_head_on = 1'b1;
    sc_head    = {pc, npc, ir};
  endtask

  initial begin
    rst = 1'b0; j = 1'b0; jPC = '0; stall = 1'b0; mem_ready = 1'b1;
    valid = 1'b0; Rdata = '0;
    @(posedge clk);
    #1;
    // Reset values, held for two cycles with memory ready.
    for (int i = 0; i < 2; i++) begin
      expect_st("reset", 0, 0, 1'b1, 32'h100);
      expect_head(32'h0, 32'h0, 32'h0);
      step();
    end

    // Release and first fetches: 0x100/0x104/0x108 -> 0xA/0xB/0xC.
    rst = 1'b1;
    exp_req.push_back(32'h100); exp_req.push_back(32'h104); exp_req.push_back(32'h108);
    exp_ins.push_back({32'h100, 32'h104, 32'hA});
    exp_ins.push_back({32'h104, 32'h108, 32'hB});
    exp_ins.push_back({32'h108, 32'h10C, 32'hC});
    expect_st("release", 1, 0, 1'b1, 32'h100);
    step();                                   // C0
    for (int i = 0; i < 5; i++) step();       // C1..C5
    auto_mem = 1'b0;                          // 0x10C response will arrive late
    exp_req.push_back(32'h10C);
    step();                                   // C6

    // Redirect while 0x10C is outstanding.
    j = 1'b1; jPC = 32'h200;
    expect_st("redir_j", 0, -1, 1'b0, 32'h0);
    step();                                   // C7
    j = 1'b0;
    expect_st("redir_drop", 0, 0, 1'b1, 32'h200);
    step();                                   // C8
    valid = 1'b1; Rdata = 32'hDEAD;           // stale response
    auto_mem = 1'b1;
    expect_st("redir_stale", 0, 0, 1'b1, 32'h200);
    step();                                   // C9

    // Fill to full with decode stalled.
    stall = 1'b1;
    exp_req.push_back(32'h200); exp_req.push_back(32'h204);
    exp_req.push_back(32'h208); exp_req.push_back(32'h20C);
    expect_st("redir_first", 1, 0, 1'b1, 32'h200);
    step();                                   // C10
    for (int i = 0; i < 7; i++) step();       // C11..C17
    for (int i = 0; i < 3; i++) begin         // C18..C20
      expect_st("full", 0, 1, 1'b1, 32'h210);
      expect_head(32'h200, 32'h204, 32'h4A);
      step();
    end
    stall = 1'b0;
    exp_ins.push_back({32'h200, 32'h204, 32'h4A});
    expect_st("full_pop", 0, 1, 1'b0, 32'h0);
    step();                                   // C21
    stall = 1'b1;
    exp_req.push_back(32'h210);
    expect_st("refill", 1, 1, 1'b1, 32'h210);
    step();                                   // C22
    step();                                   // C23
    stall = 1'b0;
    exp_ins.push_back({32'h204, 32'h208, 32'h4B});
    exp_ins.push_back({32'h208, 32'h20C, 32'h4C});
    expect_st("full2", 0, 1, 1'b0, 32'h0);
    step();                                   // C24
    exp_req.push_back(32'h214);
    step();                                   // C25

    // Redirect in the same cycle as the response; also sets up PC wrap.
    j = 1'b1; jPC = 32'hFFFF_FFFC;
    expect_st("j_valid", 0, -1, 1'b0, 32'h0);
    step();                                   // C26
    j = 1'b0;
    exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0);
    exp_ins.push_back({32'hFFFF_FFFC, 32'h0000_0000, 32'h3FFF_FFC9});
    exp_ins.push_back({32'h0000_0000, 32'h0000_0004, 32'h3FFF_FFCA});
    expect_st("after_j", 1, 0, 1'b1, 32'hFFFF_FFFC);
    step();                                   // C27
    for (int i = 0; i < 3; i++) step();       // C28..C30

    // Reset while a request is outstanding.
    auto_mem = 1'b0;
    exp_req.push_back(32'h4);
    step();                                   // C31
    rst = 1'b0;
    expect_st("reset_mid", 0, 0, 1'b1, 32'h100);
    expect_head(32'h0, 32'h0, 32'h0);
    step();                                   // C32
    rst = 1'b1; valid = 1'b1; Rdata = 32'hBAD;
    exp_req.push_back(32'h100);
    expect_st("reset_release", 1, 0, 1'b1, 32'h100);
    step();                                   // C33
    valid = 1'b1; Rdata = 32'hA; mem_ready = 1'b0;
    exp_ins.push_back({32'h100, 32'h104, 32'hA});
    step();                                   // C34
    valid = 1'b0;
    expect_st("latency", -1, 1, 1'b0, 32'h0);
    expect_head(32'h100, 32'h104, 32'hA);
    step();                                   // C35
    step();
    step();

    done = 1'b1;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
